// File: rtl/systolic_pkg.sv
// Shared widths, state encoding and the operand beat layout for the
// systolic sequencer.
package systolic_pkg;

  localparam int DATA_W    = 8;
  localparam int ACC_W     = 32;
  localparam int K_MAX_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_PUSH,
    S_CAPTURE,
    S_OUT
  } seq_state_t;

  typedef logic [1:0] res_idx_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] a1;
    logic signed [DATA_W-1:0] a2;
    logic signed [DATA_W-1:0] b1;
    logic signed [DATA_W-1:0] b2;
  } beat_t;

endpackage

// File: rtl/sequencer_operand_buf.sv
// Operand beat store: one write port fed by the load count, two read ports
// at t and t-1 so the second array row/column sees a one-cycle skew.
module sequencer_operand_buf
  import systolic_pkg::*;
#(
  parameter int K_MAX = K_MAX_DEF,
  parameter int AW    = $clog2(K_MAX)
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_idx,
  input  logic signed [DATA_W-1:0] wr_a1,
  input  logic signed [DATA_W-1:0] wr_a2,
  input  logic signed [DATA_W-1:0] wr_b1,
  input  logic signed [DATA_W-1:0] wr_b2,
  input  logic [AW-1:0]            rd_t_idx,
  input  logic [AW-1:0]            rd_tm1_idx,
  output logic signed [DATA_W-1:0] rd_a1,
  output logic signed [DATA_W-1:0] rd_b1,
  output logic signed [DATA_W-1:0] rd_a2,
  output logic signed [DATA_W-1:0] rd_b2
);

  beat_t mem_q [K_MAX];
  beat_t mem_d [K_MAX];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = '{a1: wr_a1, a2: wr_a2, b1: wr_b1, b2: wr_b2};
    end
  end

  // Contents are don't-care after reset, so the store carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_a1 = mem_q[rd_t_idx].a1;
  assign rd_b1 = mem_q[rd_t_idx].b1;
  assign rd_a2 = mem_q[rd_tm1_idx].a2;
  assign rd_b2 = mem_q[rd_tm1_idx].b2;

endmodule

// File: rtl/systolic_sequencer.sv
// Buffers one K-beat job, drives the 2x2 array through clear/feed/flush/push,
// captures C11..C22 and streams them out over valid/ready.
module systolic_sequencer
  import systolic_pkg::*;
#(
  parameter int K_MAX = K_MAX_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(K_MAX+1)-1:0]  cfg_k,
  input  logic                        op_valid,
  output logic                        op_ready,
  input  logic signed [DATA_W-1:0]    op_a1,
  input  logic signed [DATA_W-1:0]    op_a2,
  input  logic signed [DATA_W-1:0]    op_b1,
  input  logic signed [DATA_W-1:0]    op_b2,
  output logic                        arr_start,
  output logic                        arr_enable,
  output logic                        arr_push11,
  output logic                        arr_pushedge,
  output logic                        arr_push22,
  output logic signed [DATA_W-1:0]    arr_a1X,
  output logic signed [DATA_W-1:0]    arr_a2X,
  output logic signed [DATA_W-1:0]    arr_bX1,
  output logic signed [DATA_W-1:0]    arr_bX2,
  input  logic signed [ACC_W-1:0]     arr_c11,
  input  logic signed [ACC_W-1:0]     arr_c12,
  input  logic signed [ACC_W-1:0]     arr_c21,
  input  logic signed [ACC_W-1:0]     arr_c22,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic signed [ACC_W-1:0]     res_data,
  output logic [1:0]                  res_idx,
  output logic                        res_last,
  output logic                        busy
);

  localparam int KW = $clog2(K_MAX+1);
  localparam int AW = $clog2(K_MAX);

  seq_state_t              state_q, state_d;
  logic [KW-1:0]           k_q, k_d, cnt_q, cnt_d, k_in, tm1;
  res_idx_t                idx_q, idx_d;
  logic signed [ACC_W-1:0] result_q [4];
  logic signed [ACC_W-1:0] result_d [4];

  logic                    op_ready_q, op_ready_d, busy_q, busy_d;
  logic                    start_q, start_d, enable_q, enable_d, push_q, push_d;
  logic signed [DATA_W-1:0] a1_q, a1_d, a2_q, a2_d, b1_q, b1_d, b2_q, b2_d;
  logic                    res_valid_q, res_valid_d, res_last_q, res_last_d;
  logic signed [ACC_W-1:0] res_data_q, res_data_d;
  res_idx_t                res_idx_q, res_idx_d;

  logic                    op_fire, res_fire, wr_en;
  logic [AW-1:0]           wr_idx;
  logic signed [DATA_W-1:0] rd_a1, rd_b1, rd_a2, rd_b2;

  sequencer_operand_buf #(.K_MAX(K_MAX), .AW(AW)) u_buf (
    .clk        (clk),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_a1      (op_a1),
    .wr_a2      (op_a2),
    .wr_b1      (op_b1),
    .wr_b2      (op_b2),
    .rd_t_idx   (cnt_d[AW-1:0]),
    .rd_tm1_idx (tm1[AW-1:0]),
    .rd_a1      (rd_a1),
    .rd_b1      (rd_b1),
    .rd_a2      (rd_a2),
    .rd_b2      (rd_b2)
  );

  always_comb begin
    op_fire  = op_valid && op_ready_q;
    res_fire = res_valid_q && res_ready;

    if (cfg_k == '0)               k_in = KW'(1);
    else if (cfg_k > KW'(K_MAX))   k_in = KW'(K_MAX);
    else                           k_in = cfg_k;

    state_d  = state_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    result_d = result_q;
    wr_en    = 1'b0;
    wr_idx   = cnt_q[AW-1:0];

    unique case (state_q)
      S_IDLE: if (op_fire) begin
        k_d     = k_in;
        wr_en   = 1'b1;
        wr_idx  = '0;
        cnt_d   = KW'(1);
        state_d = (k_in == KW'(1)) ? S_CLEAR : S_LOAD;
      end
      S_LOAD: if (op_fire) begin
        wr_en = 1'b1;
        cnt_d = cnt_q + KW'(1);
        if (cnt_q == k_q - KW'(1)) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        if (cnt_q == k_q) state_d = S_FLUSH;
        else              cnt_d   = cnt_q + KW'(1);
      end
      S_FLUSH: state_d = S_PUSH;
      S_PUSH:  state_d = S_CAPTURE;
      S_CAPTURE: begin
        result_d = '{arr_c11, arr_c12, arr_c21, arr_c22};
        idx_d    = '0;
        state_d  = S_OUT;
      end
      S_OUT: if (res_fire) begin
        if (idx_q == 2'd3) state_d = S_IDLE;
        else               idx_d   = idx_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    tm1         = cnt_d - KW'(1);
    op_ready_d  = (state_d == S_IDLE) || (state_d == S_LOAD);
    busy_d      = (state_d != S_IDLE);
    start_d     = (state_d == S_CLEAR);
    enable_d    = (state_d == S_FEED) || (state_d == S_FLUSH);
    push_d      = (state_d == S_PUSH);
    a1_d = '0;
    b1_d = '0;
    a2_d = '0;
    b2_d = '0;
    if (state_d == S_FEED) begin
      if (cnt_d < k_d) begin
        a1_d = rd_a1;
        b1_d = rd_b1;
      end
      if (cnt_d != '0) begin
        a2_d = rd_a2;
        b2_d = rd_b2;
      end
    end
    res_valid_d = (state_d == S_OUT);
    res_idx_d   = (state_d == S_OUT) ? idx_d : '0;
    res_data_d  = (state_d == S_OUT) ? result_d[idx_d] : '0;
    res_last_d  = (state_d == S_OUT) && (idx_d == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      result_q    <= '{default: '0};
      op_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      enable_q    <= 1'b0;
      push_q      <= 1'b0;
      a1_q        <= '0;
      a2_q        <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      res_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      op_ready_q  <= op_ready_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      enable_q    <= enable_d;
      push_q      <= push_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
      res_last_q  <= res_last_d;
    end
  end

  assign op_ready     = op_ready_q;
  assign busy         = busy_q;
  assign arr_start    = start_q;
  assign arr_enable   = enable_q;
  assign arr_push11   = push_q;
  assign arr_pushedge = push_q;
  assign arr_push22   = push_q;
  assign arr_a1X      = a1_q;
  assign arr_a2X      = a2_q;
  assign arr_bX1      = b1_q;
  assign arr_bX2      = b2_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_idx      = res_idx_q;
  assign res_last     = res_last_q;

endmodule
